// File: rtl/display_timing_gen.sv
// Display timing generator: free-running pixel/line counters with registered
// coordinate, sync, video_on and frame_tick outputs (one cycle behind the counters).
module display_timing_gen #(
    parameter int   H_ACTIVE   = 1024,
    parameter int   H_FP       = 24,
    parameter int   H_SYNC     = 136,
    parameter int   H_BP       = 144,
    parameter int   V_ACTIVE   = 768,
    parameter int   V_FP       = 3,
    parameter int   V_SYNC     = 6,
    parameter int   V_BP       = 29,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on,
    output logic [11:0] pixel_row,
    output logic [11:0] pixel_column,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_VIS       = 13'(H_ACTIVE);
    localparam logic [12:0] V_VIS       = 13'(V_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_SYNC_BEG  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END  = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] r_hcnt;
    logic [11:0] r_vcnt;
    logic [11:0] r_row;
    logic [11:0] r_col;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_video_on;
    logic        r_frame_tick;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_video_on;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_frame_tick;
    logic [12:0] w_h_ext;
    logic [12:0] w_v_ext;

    // Decode the current counter position into next-cycle output levels.
    always_comb begin
        w_h_ext      = {1'b0, r_hcnt};
        w_v_ext      = {1'b0, r_vcnt};
        w_h_last     = (r_hcnt == H_LAST);
        w_v_last     = (r_vcnt == V_LAST);
        w_video_on   = (w_h_ext < H_VIS) && (w_v_ext < V_VIS);
        w_frame_tick = (r_hcnt == 12'd0) && (r_vcnt == 12'd0);
        if ((w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END)) begin
            w_hsync = H_SYNC_POL;
        end else begin
            w_hsync = ~H_SYNC_POL;
        end
        // Vertical sync depends on the line count only, so it moves with the line wrap.
        if ((w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END)) begin
            w_vsync = V_SYNC_POL;
        end else begin
            w_vsync = ~V_SYNC_POL;
        end
    end

    // Advance the raster counters and register the decoded outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hcnt       <= 12'd0;
            r_vcnt       <= 12'd0;
            r_row        <= 12'd0;
            r_col        <= 12'd0;
            r_video_on   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_hsync      <= ~H_SYNC_POL;
            r_vsync      <= ~V_SYNC_POL;
        end else begin
            r_row        <= r_vcnt;
            r_col        <= r_hcnt;
            r_video_on   <= w_video_on;
            r_frame_tick <= w_frame_tick;
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            if (w_h_last) begin
                r_hcnt <= 12'd0;
                if (w_v_last) begin
                    r_vcnt <= 12'd0;
                end else begin
                    r_vcnt <= r_vcnt + 12'd1;
                end
            end else begin
                r_hcnt <= r_hcnt + 12'd1;
            end
        end
    end

    assign horiz_sync   = r_hsync;
    assign vert_sync    = r_vsync;
    assign video_on     = r_video_on;
    assign pixel_row    = r_row;
    assign pixel_column = r_col;
    assign frame_tick   = r_frame_tick;

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Display timing generator for the 1024x768 video path.
- Runs at 75 MHz and produces the pixel_row/pixel_column stream consumed by the address scaler, plus horizontal/vertical sync and the video_on gate for the colorizer and VGA pins.
- Defaults give 1024x768 at about 70 Hz: 1328 x 806 total, 75e6/(1328*806) = 70.07 Hz.
- This block is the source end of the pixel-coordinate interface.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (clocks)
H_SYNC, 136, horizontal sync width (clocks)
H_BP, 144, horizontal back porch (clocks)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
H_SYNC_POL, 0, active level of horiz_sync
V_SYNC_POL, 0, active level of vert_sync

Ports:
clock  input  1  75 MHz pixel clock, rising edge
reset  input  1  synchronous, active-high reset
horiz_sync  output  1  horizontal sync, active level H_SYNC_POL
vert_sync  output  1  vertical sync, active level V_SYNC_POL
video_on  output  1  high only inside the visible area
pixel_row  output  12  current line count 0..V_TOTAL-1
pixel_column  output  12  current pixel count 0..H_TOTAL-1
frame_tick  output  1  one-cycle pulse when outputs present (0,0)

Behaviour:
- Clock and reset: one clock domain (clock). reset is synchronous and active-high, sampled on the rising edge of clock; no asynchronous paths.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be at most 4096.
- Internal counters: hcnt runs 0..H_TOTAL-1 and wraps to 0. vcnt increments only when hcnt wraps, runs 0..V_TOTAL-1 and wraps to 0 on the same edge hcnt wraps from H_TOTAL-1.
- Output registration: all outputs are registered. On each edge with reset low, outputs load functions of the pre-increment (hcnt,vcnt) while the counters advance. Outputs therefore lag the counters by one cycle and carry no combinational paths.
- Output functions of (h,v):
  - pixel_column=h, pixel_row=v (raw counts, also valid during blanking).
  - video_on = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - horiz_sync = H_SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_SYNC_POL.
  - vert_sync = V_SYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~V_SYNC_POL. It is a whole-line function, so it changes only on the edge where pixel_column shows 0.
  - frame_tick = (h==0)&&(v==0).
- Reset values (reset high at an edge): hcnt=0, vcnt=0, pixel_row=0, pixel_column=0, video_on=0, frame_tick=0, horiz_sync=~H_SYNC_POL, vert_sync=~V_SYNC_POL.
- First edge after reset release: outputs show (0,0) with video_on=1 and frame_tick=1.
- Reset mid-frame takes effect at the next edge regardless of position. No partial-line completion; the next frame restarts cleanly at (0,0).
- Consumers must gate with video_on, because blanking coordinates exceed the visible range (e.g. pixel_row up to 805).
- Frame length is exactly H_TOTAL*V_TOTAL clocks, which is 1,070,368 at the defaults. frame_tick period equals the frame length.
- Counter widths are 12 bits. No overflow is possible given the totals constraint.

Test Plan:
- Reset: hold reset 5 cycles -> all outputs at the reset values above with syncs high; first edge after release gives pixel_row=0, pixel_column=0, video_on=1, frame_tick=1.
- Line timing: count 1328 cycles from (0,0) -> video_on falls when pixel_column goes 1023->1024; horiz_sync low exactly for columns 1048..1183 (136 cycles); column 1327->0 increments pixel_row to 1.
- Vertical timing: run a full frame -> video_on never high for rows 768..805; vert_sync low exactly for rows 771..776 (6*1328=7968 cycles) and toggles only at column 0.
- Frame wrap: at row 805, column 1327 -> next output (0,0) with frame_tick=1; frame_tick period is exactly 1,070,368 cycles with no other pulses.
- Mid-frame reset: assert reset one cycle at row 400, column 600 -> next edge shows the reset values; first edge after release shows (0,0) with frame_tick=1.
- Polarity: build with H_SYNC_POL=1, V_SYNC_POL=1 -> same windows with inverted levels; syncs low during reset.
